// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: branch opcode, 2-bit counter states,
// and B-type immediate extraction.
package bp_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Sign-extended B-type branch offset.
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of 2-bit saturating counters.
// One asynchronous read port and one write port with saturating update.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CTR = WNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr_c,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [1:0] r_ctr [DEPTH];
    logic [1:0] w_wr_cur;
    logic [1:0] w_wr_nxt;

    // Read returns the pre-update value when read and write hit the same entry.
    assign o_rd_ctr_c = r_ctr[i_rd_idx];

    always_comb begin
        w_wr_cur = r_ctr[i_wr_idx];
        w_wr_nxt = w_wr_cur;
        if (i_wr_taken && (w_wr_cur != ST)) begin
            w_wr_nxt = w_wr_cur + 2'd1;
        end else if (!i_wr_taken && (w_wr_cur != SNT)) begin
            w_wr_nxt = w_wr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_ctr[i] <= INIT_CTR;
            end
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= w_wr_nxt;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch predictor: PC xor global history indexes a PHT,
// with history recovery on mispredict and a saturating mispredict counter.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned GHR_W    = 6,
    parameter logic [1:0]  INIT_CTR = 2'b01,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic [31:0]      pred_inst,
    output logic             pred_is_branch,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic [31:0]      pred_fallthru,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [GHR_W-1:0] res_ghr,
    input  logic             res_taken,
    input  logic             res_pred_taken,
    output logic             mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [GHR_W-1:0] r_ghr;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic [1:0]       w_pred_ctr;
    logic             w_ctr_taken;
    logic             w_unused_res_pc;

    assign w_unused_res_pc = &{1'b0, res_pc[31:IDX_W+2], res_pc[1:0]};

    assign w_pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
    assign w_res_idx  = res_pc[IDX_W+1:2]  ^ IDX_W'(res_ghr);

    bp_pht #(
        .IDX_W    (IDX_W),
        .INIT_CTR (INIT_CTR)
    ) u_pht (
        .clk        (clk),
        .rst_n      (rst),
        .i_rd_idx   (w_pred_idx),
        .o_rd_ctr_c (w_pred_ctr),
        .i_wr_en    (res_valid),
        .i_wr_idx   (w_res_idx),
        .i_wr_taken (res_taken)
    );

    assign w_ctr_taken    = (w_pred_ctr == WT) || (w_pred_ctr == ST);
    assign pred_is_branch = (pred_inst[6:0] == OPC_BRANCH);
    assign pred_taken     = pred_is_branch & w_ctr_taken;
    assign pred_fallthru  = pred_pc + 32'd4;
    assign pred_target    = pred_taken ? (pred_pc + b_imm(pred_inst)) : pred_fallthru;
    assign pred_ghr       = r_ghr;

    assign mispredict     = res_valid & (res_taken ^ res_pred_taken);
    assign mispredict_cnt = r_cnt;

    // Recovery from a mispredict overrides the speculative shift of a fetched branch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ghr <= '0;
        end else if (mispredict) begin
            r_ghr <= {res_ghr[GHR_W-2:0], res_taken};
        end else if (pred_valid && pred_is_branch) begin
            r_ghr <= {r_ghr[GHR_W-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (mispredict && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios plus random
// traffic compared against a table-of-integers reference model.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [31:0] pred_inst;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [3:0]  res_ghr;
    logic        res_taken;
    logic        res_pred_taken;

    logic        a_is_br, a_taken, a_mis;
    logic [31:0] a_target, a_fall;
    logic [3:0]  a_ghr;
    logic [15:0] a_cnt;
    logic        b_is_br, b_taken, b_mis;
    logic [31:0] b_target, b_fall;
    logic [3:0]  b_ghr;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    int m_pht [16];
    int m_ghr;
    int m_cnt16;
    int m_cnt2;

    always #5 clk = ~clk;

    gshare_predictor #(.IDX_W(4), .GHR_W(4), .INIT_CTR(2'b01), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_inst(pred_inst),
        .pred_is_branch(a_is_br), .pred_taken(a_taken), .pred_target(a_target),
        .pred_fallthru(a_fall), .pred_ghr(a_ghr),
        .res_valid(res_valid), .res_pc(res_pc), .res_ghr(res_ghr),
        .res_taken(res_taken), .res_pred_taken(res_pred_taken),
        .mispredict(a_mis), .mispredict_cnt(a_cnt)
    );

    gshare_predictor #(.IDX_W(4), .GHR_W(4), .INIT_CTR(2'b01), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_inst(pred_inst),
        .pred_is_branch(b_is_br), .pred_taken(b_taken), .pred_target(b_target),
        .pred_fallthru(b_fall), .pred_ghr(b_ghr),
        .res_valid(res_valid), .res_pc(res_pc), .res_ghr(res_ghr),
        .res_taken(res_taken), .res_pred_taken(res_pred_taken),
        .mispredict(b_mis), .mispredict_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc, input int g);
        return int'((pc >> 2) & 32'hF) ^ (g & 15);
    endfunction

    function automatic int m_offset(input logic [31:0] inst);
        int off;
        off = int'((inst >> 31) & 1) * 4096 + int'((inst >> 7) & 1) * 2048
            + int'((inst >> 25) & 63) * 32 + int'((inst >> 8) & 15) * 2;
        if (off >= 4096) off -= 8192;
        return off;
    endfunction

    function automatic bit m_is_br(input logic [31:0] inst);
        return (inst & 32'h7F) == 32'h63;
    endfunction

    function automatic bit m_pred_taken();
        return m_is_br(pred_inst) && (m_pht[m_idx(pred_pc, m_ghr)] >= 2);
    endfunction

    task automatic model_reset();
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr   = 0;
        m_cnt16 = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_edge();
        bit mis, pt;
        int ri;
        if (!rst) return;
        pt  = m_pred_taken();
        mis = res_valid && (res_taken != res_pred_taken);
        if (res_valid) begin
            ri = m_idx(res_pc, int'(res_ghr));
            if (res_taken) m_pht[ri] = (m_pht[ri] == 3) ? 3 : m_pht[ri] + 1;
            else           m_pht[ri] = (m_pht[ri] == 0) ? 0 : m_pht[ri] - 1;
        end
        if (mis) begin
            m_ghr = ((int'(res_ghr) * 2) + int'(res_taken)) % 16;
        end else if (pred_valid && m_is_br(pred_inst)) begin
            m_ghr = ((m_ghr * 2) + int'(pt)) % 16;
        end
        if (mis) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic check_all(input string tag);
        logic        e_br, e_tk, e_mis;
        logic [31:0] e_fall, e_tgt;
        e_br   = m_is_br(pred_inst);
        e_tk   = m_pred_taken();
        e_fall = pred_pc + 32'd4;
        e_tgt  = e_tk ? pred_pc + 32'(m_offset(pred_inst)) : e_fall;
        e_mis  = res_valid && (res_taken != res_pred_taken);
        chk({tag, ".is_branch"}, 32'(a_is_br), 32'(e_br));
        chk({tag, ".taken"},     32'(a_taken), 32'(e_tk));
        chk({tag, ".target"},    a_target, e_tgt);
        chk({tag, ".fallthru"},  a_fall, e_fall);
        chk({tag, ".ghr"},       32'(a_ghr), 32'(m_ghr));
        chk({tag, ".mispredict"}, 32'(a_mis), 32'(e_mis));
        chk({tag, ".cnt16"},     32'(a_cnt), 32'(m_cnt16));
        chk({tag, ".n2.taken"},  32'(b_taken), 32'(e_tk));
        chk({tag, ".n2.target"}, b_target, e_tgt);
        chk({tag, ".n2.misc"},   {b_fall[27:0], b_ghr}, {e_fall[27:0], 4'(m_ghr)});
        chk({tag, ".n2.flags"},  32'({b_is_br, b_mis}), 32'({e_br, e_mis}));
        chk({tag, ".cnt2"},      32'(b_cnt), 32'(m_cnt2));
    endtask

    // Inputs are driven just after a falling edge; outputs checked 1ns later.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        pred_valid = 1'b0; pred_pc = 32'h0; pred_inst = 32'h0;
        res_valid = 1'b0; res_pc = 32'h0; res_ghr = 4'h0;
        res_taken = 1'b0; res_pred_taken = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [3:0] g,
                           input logic tk, input logic ptk);
        res_valid = 1'b1; res_pc = pc; res_ghr = g;
        res_taken = tk; res_pred_taken = ptk;
    endtask

    localparam logic [31:0] BR_P16 = 32'h0000_0863;

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        #1;
        pred_pc = 32'h40; pred_inst = BR_P16;
        #1;
        check_all("in_reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        // Fresh predictor: weakly not-taken, falls through.
        idle(); pred_valid = 1'b0; pred_pc = 32'h40; pred_inst = BR_P16;
        step("cold_predict");

        // Train entry 0 to strongly taken, then predict taken to 0x50.
        idle(); resolve(32'h40, 4'h0, 1'b1, 1'b1); step("train1");
        idle(); resolve(32'h40, 4'h0, 1'b1, 1'b1); step("train2");
        idle(); pred_pc = 32'h40; pred_inst = BR_P16; step("hot_predict");

        // Ceiling: four more taken, then walk down through the floor.
        for (int i = 0; i < 4; i++) begin
            idle(); resolve(32'h40, 4'h0, 1'b1, 1'b1); pred_pc = 32'h40; pred_inst = BR_P16;
            step("ceiling");
        end
        for (int i = 0; i < 6; i++) begin
            idle(); resolve(32'h40, 4'h0, 1'b0, 1'b0); pred_pc = 32'h40; pred_inst = BR_P16;
            step("floor");
        end
        for (int i = 0; i < 3; i++) begin
            idle(); resolve(32'h40, 4'h0, 1'b1, 1'b1); pred_pc = 32'h40; pred_inst = BR_P16;
            step("climb");
        end

        // Recovery beats a concurrent fetched branch shift.
        idle(); resolve(32'h80, 4'b0111, 1'b1, 1'b0); step("ghr_to_f");
        idle(); pred_pc = 32'h1C; pred_inst = BR_P16; step("ghr_is_f");
        idle(); resolve(32'h24, 4'b0010, 1'b1, 1'b0);
        pred_valid = 1'b1; pred_pc = 32'h1C; pred_inst = BR_P16;
        step("recover");
        idle(); step("after_recover");

        // Same-index predict and update: pre-update value this cycle.
        idle(); rst = 1'b0; model_reset(); #1; rst = 1'b1; @(negedge clk);
        idle(); resolve(32'h48, 4'h0, 1'b1, 1'b1); pred_pc = 32'h48; pred_inst = BR_P16;
        step("same_idx_now");
        idle(); pred_pc = 32'h48; pred_inst = BR_P16; step("same_idx_next");

        // Five mispredicts: 2-bit counter pins at 3.
        for (int i = 0; i < 5; i++) begin
            idle(); resolve(32'h100 + 32'(i * 4), 4'(i), 1'b0, 1'b1); step("mis_sat");
        end
        idle(); step("mis_sat_end");

        // Random traffic with one asynchronous reset in the middle.
        for (int n = 0; n < 400; n++) begin
            pred_valid     = 1'($urandom_range(0, 1));
            pred_pc        = {$urandom} & 32'hFFFF_FFFC;
            pred_inst      = ($urandom_range(0, 3) != 0) ? (({$urandom} & 32'hFFFF_FF80) | 32'h63)
                                                         : {$urandom};
            res_valid      = 1'($urandom_range(0, 1));
            res_pc         = {$urandom};
            res_ghr        = 4'($urandom);
            res_taken      = 1'($urandom_range(0, 1));
            res_pred_taken = ($urandom_range(0, 3) == 0) ? ~res_taken : res_taken;
            if (n == 200) begin
                #2;
                rst = 1'b0;
                model_reset();
                #1;
                check_all("mid_reset");
                @(negedge clk);
                rst = 1'b1;
            end
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL expose the following parameters:
  IDX_W, 6, log2 of the pattern history table (PHT) depth.
  GHR_W, 6, global history register length; legal range 2..IDX_W.
  INIT_CTR, 2'b01, reset value of every 2-bit PHT counter.
  CNT_W, 16, width of the mispredict statistics counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst.
REQ-003 The block SHALL have the following ports:
  clk  in  1  clock, all state updates on rising edge.
  rst  in  1  asynchronous active-low reset.
  pred_valid  in  1  fetch presents a new instruction this cycle, one pulse per instruction.
  pred_pc  in  32  fetch PC.
  pred_inst  in  32  fetched instruction word.
  pred_is_branch  out  1  pred_inst[6:0]==7'b1100011.
  pred_taken  out  1  predicted direction.
  pred_target  out  32  predicted next PC.
  pred_fallthru  out  32  pred_pc+4, for recovery.
  pred_ghr  out  GHR_W  GHR snapshot before this branch's shift, carried down the pipeline.
  res_valid  in  1  a conditional branch resolves in EX this cycle.
  res_pc  in  32  PC of the resolving branch.
  res_ghr  in  GHR_W  its carried pred_ghr snapshot.
  res_taken  in  1  actual outcome.
  res_pred_taken  in  1  its carried pred_taken.
  mispredict  out  1  res_valid & (res_taken ^ res_pred_taken), combinational.
  mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Function
REQ-004 PHT index SHALL be pc[IDX_W+1:2] XOR {zero-extend to IDX_W of ghr}, for both predict (pred_pc, live GHR) and update (res_pc, res_ghr).
REQ-005 pred_taken SHALL be pred_is_branch & PHT[idx][1]; it SHALL be 0 for non-branches.
REQ-006 pred_target SHALL be pred_pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}) when pred_taken, else pred_pc+4; 32-bit wrap-around, no overflow flag.
REQ-007 Prediction outputs SHALL be combinational (zero latency) from pred_pc, pred_inst, PHT and GHR.
REQ-008 On a clock edge with res_valid=1, PHT[update idx] SHALL saturate-increment if res_taken else saturate-decrement (00 floor, 11 ceiling), regardless of mispredict.
REQ-009 On an edge with mispredict=1, GHR SHALL load {res_ghr[GHR_W-2:0], res_taken}.
REQ-010 Else on an edge with pred_valid & pred_is_branch, GHR SHALL load {GHR[GHR_W-2:0], pred_taken}; otherwise GHR holds.
REQ-011 Simultaneous mispredict and branch predict: recovery (REQ-009) SHALL win; the fetched branch's shift is discarded.
REQ-012 Same-index read and update in one cycle: prediction SHALL use the pre-update counter value.
REQ-013 On each edge with mispredict=1, mispredict_cnt SHALL increment, holding at all-ones.

Reset
REQ-014 rst low SHALL immediately set all PHT entries to INIT_CTR, GHR to 0, mispredict_cnt to 0, including mid-operation; state changes resume on the first rising edge after rst deasserts.
REQ-015 During reset, pred_taken SHALL reflect INIT_CTR[1] for branches and mispredict SHALL follow its combinational definition.

Structure
REQ-016 A shared package bp_pkg SHALL hold OPC_BRANCH (7'b1100011), counter localparams SNT=00, WNT=01, WT=10, ST=11, and the B-immediate extraction function.
REQ-017 The PHT array with one async read port, one write port and saturating update SHALL be a sub-module named bp_pht.

Verification (IDX_W=4, GHR_W=4)
REQ-018 Reset, then pred_pc=0x40, branch inst with offset +16 -> pred_taken=0, pred_target=0x44, pred_fallthru=0x44, pred_ghr=0.
REQ-019 Two resolves pc=0x40, res_ghr=0, taken=1 -> counter 01->10->11; then predict pc=0x40 with GHR=0 -> pred_taken=1, pred_target=0x50.
REQ-020 Counter at 00 plus three not-taken resolves stays 00; at 11 plus four taken resolves stays 11.
REQ-021 GHR=4'b1111, resolve res_ghr=4'b0010, res_taken=1, res_pred_taken=0 with concurrent branch predict -> mispredict=1, next GHR=4'b0101, mispredict_cnt+1.
REQ-022 Predict and update on the same index in one cycle with counter 01 and res_taken=1 -> pred_taken=0 that cycle, 1 next cycle; CNT_W=2 with five mispredicts -> mispredict_cnt=3.
